// File: rtl/sine_voice_sequencer.sv
// Time-multiplexed DDS voice mixer: one shared registered-read sine LUT serves
// NUM_VOICES phase accumulators, which are summed into one unsigned sample per tick.
module sine_voice_sequencer #(
    parameter int NUM_VOICES       = 4,
    parameter int ACCUMULATOR_BITS = 24,
    parameter int OUTPUT_BITS      = 12,
    parameter int LUT_ADDR_BITS    = 10
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       sample_tick,
    input  logic                                       cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0]              cfg_voice,
    input  logic [ACCUMULATOR_BITS-1:0]                cfg_freq,
    input  logic                                       cfg_gate,
    output logic [LUT_ADDR_BITS-1:0]                   lut_addr,
    input  logic [OUTPUT_BITS-1:0]                     lut_data,
    output logic [OUTPUT_BITS+$clog2(NUM_VOICES)-1:0]  sample_out,
    output logic                                       sample_valid,
    output logic                                       busy,
    output logic                                       overrun
);
    localparam int VB   = $clog2(NUM_VOICES);
    localparam int MIXW = OUTPUT_BITS + VB;
    localparam logic [MIXW-1:0] MIDSCALE     = MIXW'(1) << (OUTPUT_BITS - 1);
    localparam logic [MIXW-1:0] RESET_SAMPLE = MIXW'(NUM_VOICES) << (OUTPUT_BITS - 1);
    localparam logic [VB-1:0]   LAST_VOICE   = VB'(NUM_VOICES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_ACC  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [VB-1:0]                r_voice;
    logic [MIXW-1:0]              r_mix;
    logic [MIXW-1:0]              w_addend;
    logic [LUT_ADDR_BITS-1:0]     r_lut_addr;
    logic [MIXW-1:0]              r_sample_out;
    logic                         r_sample_valid;
    logic                         r_busy;
    logic                         r_overrun;
    logic [ACCUMULATOR_BITS-1:0]  r_phase [NUM_VOICES];
    logic [ACCUMULATOR_BITS-1:0]  r_freq  [NUM_VOICES];
    logic                         r_gate  [NUM_VOICES];

    assign lut_addr     = r_lut_addr;
    assign sample_out   = r_sample_out;
    assign sample_valid = r_sample_valid;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

    // Next-state decode and the per-voice addend (silent voices contribute midscale).
    always_comb begin
        w_next   = r_state;
        w_addend = MIDSCALE;
        if (r_gate[r_voice]) begin
            w_addend = {{VB{1'b0}}, lut_data};
        end else begin
            w_addend = MIDSCALE;
        end
        case (r_state)
            S_IDLE: begin
                if (sample_tick) begin
                    w_next = S_ADDR;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_ADDR: w_next = S_WAIT;
            S_WAIT: w_next = S_ACC;
            S_ACC: begin
                if (r_voice == LAST_VOICE) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_ADDR;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Sequencer state, mix accumulator, LUT address and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_voice        <= '0;
            r_mix          <= '0;
            r_lut_addr     <= '0;
            r_sample_out   <= RESET_SAMPLE;
            r_sample_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_busy         <= (w_next != S_IDLE);
            r_sample_valid <= 1'b0;
            if (sample_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (sample_tick) begin
                        r_mix   <= '0;
                        r_voice <= '0;
                    end
                end
                S_ADDR: r_lut_addr <= r_phase[r_voice][ACCUMULATOR_BITS-1 -: LUT_ADDR_BITS];
                S_ACC: begin
                    r_mix <= r_mix + w_addend;
                    if (r_voice != LAST_VOICE) begin
                        r_voice <= r_voice + VB'(1);
                    end
                end
                S_DONE: begin
                    r_sample_out   <= r_mix;
                    r_sample_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Per-voice registers; a gate rising edge restarts the phase and wins over the ADDR step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_phase[i] <= '0;
                r_freq[i]  <= '0;
                r_gate[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if ((r_state == S_ADDR) && (r_voice == VB'(i))) begin
                    r_phase[i] <= r_phase[i] + r_freq[i];
                end
                if (cfg_we && (cfg_voice == VB'(i))) begin
                    r_freq[i] <= cfg_freq;
                    r_gate[i] <= cfg_gate;
                    if (cfg_gate && !r_gate[i]) begin
                        r_phase[i] <= '0;
                    end
                end
            end
        end
    end

endmodule
